median_3x3_filter: RTL and testbench
====================================

Name: median_3x3_filter

Overview:
- Downstream consumer of the 3x3 window preparation stage.
- Accepts one nine-pixel 8-bit window per valid strobe and produces the median over a fixed 3-stage pipeline.
- Tracks output position within a WIDTH x HEIGHT frame and flags the last pixel of each frame.
- Feeds the output/writeback stage of the filter chain.

Parameters:
- WIDTH, 640, pixels per line; equals the DEPTH used by the preparation stage; minimum 3.
- HEIGHT, 480, lines per frame; minimum 3.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (asserted at 0)
- done_i  input  1  window valid strobe; one window per cycle high
- data0_i..data8_i  input  8 each  window pixels, row-major; data0 top-left, data4 centre, data8 bottom-right
- data_o  output  8  median pixel
- done_o  output  1  data_o valid strobe
- frame_done_o  output  1  one-cycle pulse coincident with done_o for the last pixel of a frame

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers, data_o, done_o, frame_done_o, col_cnt, row_cnt clear to 0 immediately; held while rst=0.
- Stage 1 (cycle after done_i sampled high): sort each row triple into low/mid/high (rows {d0,d1,d2}, {d3,d4,d5}, {d6,d7,d8}); 9 registered results.
- Stage 2: max_of_lows = max(L0,L1,L2); med_of_mids = median(M0,M1,M2); min_of_highs = min(H0,H1,H2); registered.
- Stage 3: data_o = median(max_of_lows, med_of_mids, min_of_highs); registered.
- Latency: exactly 3 cycles from done_i high at edge N to done_o high after edge N+3. Valid bit travels with data through a 3-deep shift register.
- Throughput: one window per cycle. Back-to-back done_i gives back-to-back done_o. Gaps are preserved exactly, with no bubbles inserted or removed.
- Pipeline registers load only when the corresponding valid bit is set. data_o holds its last value while done_o=0.
- Comparisons are unsigned 8-bit. Ties resolve to either equal value; the result is identical.
- Position counters advance on each done_o:
  - col_cnt counts 0..WIDTH-1.
  - On wrap, col_cnt goes to 0 and row_cnt increments (0..HEIGHT-1).
  - On wrap of both, both counters go to 0.
- frame_done_o=1 exactly when done_o=1 and col_cnt=WIDTH-1 and row_cnt=HEIGHT-1. The next frame starts at (0,0) with no idle cycle required.
- Reset mid-frame: in-flight windows are discarded; the next output is treated as (0,0).
- done_i held low indefinitely: outputs and counters are frozen and done_o=0.
- Counter widths are $clog2(WIDTH) and $clog2(HEIGHT); no overflow beyond the stated wrap.

Optional Feature:
- Macro: MEDIAN_BORDER_ZERO_EN.
- Defined: when done_o=1 and the output position is on the frame border (row_cnt=0, row_cnt=HEIGHT-1, col_cnt=0 or col_cnt=WIDTH-1), data_o is forced to 8'h00. Timing, done_o and frame_done_o are unchanged.
- Undefined: data_o is always the computed median; border positions are not special-cased.

Test Plan:
- Reset/latency: after reset, one window d0..d8 = 9,1,8,2,7,3,6,4,5 with done_i for 1 cycle -> done_o high exactly 3 cycles later, data_o=5; all outputs 0 during reset.
- Sorting corners: all-equal window 8'hAA -> AA; window 0,0,0,0,255,255,255,255,255 -> 255; window 255,255,255,255,0,0,0,0,0 -> 0; ascending 0..8 -> 4.
- Streaming/gaps: 10 back-to-back windows then pattern done_i=1,0,1,0 -> done_o shows an identical pattern delayed 3 cycles; each data_o matches a software median model.
- Frame boundary (WIDTH=4, HEIGHT=3): 12 windows -> frame_done_o pulses only with the 12th done_o; 13th window reported as (0,0) with no frame_done_o.
- Async reset mid-stream: assert rst=0 between edges with 2 windows in flight -> done_o drops immediately, no stale output after release; next frame_done_o after 12 more windows.
- Border feature (WIDTH=4, HEIGHT=3, MEDIAN_BORDER_ZERO_EN defined, all windows 8'h80) -> data_o=8'h80 only for positions (1,1) and (1,2); all others 0. Without the macro, all 12 outputs are 8'h80.

Source files
------------

// File: rtl/median_3x3_filter_if.sv
// Window/median handshake bundle for median_3x3_filter.
// master: window producer / result consumer side; slave: the filter itself.
interface median_3x3_filter_if;
  logic       done_i;
  logic [7:0] data0_i;
  logic [7:0] data1_i;
  logic [7:0] data2_i;
  logic [7:0] data3_i;
  logic [7:0] data4_i;
  logic [7:0] data5_i;
  logic [7:0] data6_i;
  logic [7:0] data7_i;
  logic [7:0] data8_i;
  logic [7:0] data_o;
  logic       done_o;
  logic       frame_done_o;

  modport master (
    output done_i, data0_i, data1_i, data2_i, data3_i, data4_i, data5_i, data6_i, data7_i,
           data8_i,
    input  data_o, done_o, frame_done_o
  );

  modport slave (
    input  done_i, data0_i, data1_i, data2_i, data3_i, data4_i, data5_i, data6_i, data7_i,
           data8_i,
    output data_o, done_o, frame_done_o
  );
endinterface

// File: rtl/median_3x3_filter.sv
// 3x3 median filter: input capture, row sort, column reduce, final median.
// Result appears 3 cycles after the edge that samples done_i; frame position tracked per output.
// Optional macro MEDIAN_BORDER_ZERO_EN forces frame-border outputs to zero.
module median_3x3_filter #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480
) (
  input logic                clk,
  input logic                rst,
  median_3x3_filter_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(HEIGHT - 1);

  function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic [8:0][7:0] win_d, win_q;
  logic            v0_q, v1_q, v2_q;
  logic [2:0][7:0] lo_d, mi_d, hi_d, lo_q, mi_q, hi_q;
  logic [7:0]      red_lo_d, red_mi_d, red_hi_d, red_lo_q, red_mi_q, red_hi_q;
  logic [7:0]      data_d, data_q;
  logic            done_q, frame_d, frame_q;
  logic [CW-1:0]   col_d, col_q;
  logic [RW-1:0]   row_d, row_q;

  assign win_d = {bus.data8_i, bus.data7_i, bus.data6_i, bus.data5_i, bus.data4_i,
                  bus.data3_i, bus.data2_i, bus.data1_i, bus.data0_i};

  // Row sort of the captured window into low/mid/high per row
  always_comb begin
    lo_d = '0;
    mi_d = '0;
    hi_d = '0;
    for (int r = 0; r < 3; r++) begin
      lo_d[r] = min2(min2(win_q[3*r], win_q[3*r+1]), win_q[3*r+2]);
      mi_d[r] = med3(win_q[3*r], win_q[3*r+1], win_q[3*r+2]);
      hi_d[r] = max2(max2(win_q[3*r], win_q[3*r+1]), win_q[3*r+2]);
    end
  end

  // Column reduction: the median must lie between these three candidates
  always_comb begin
    red_lo_d = max2(max2(lo_q[0], lo_q[1]), lo_q[2]);
    red_mi_d = med3(mi_q[0], mi_q[1], mi_q[2]);
    red_hi_d = min2(min2(hi_q[0], hi_q[1]), hi_q[2]);
  end

  // Final median, frame position bookkeeping and optional border blanking
  always_comb begin
    data_d  = med3(red_lo_q, red_mi_q, red_hi_q);
    frame_d = v2_q && (col_q == ColLast) && (row_q == RowLast);
    col_d   = col_q;
    row_d   = row_q;
`ifdef MEDIAN_BORDER_ZERO_EN
    if ((col_q == '0) || (col_q == ColLast) || (row_q == '0) || (row_q == RowLast)) begin
      data_d = 8'h00;
    end
`endif
    if (v2_q) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Pipeline registers; each stage loads only when its valid bit is set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q    <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      lo_q     <= '0;
      mi_q     <= '0;
      hi_q     <= '0;
      red_lo_q <= '0;
      red_mi_q <= '0;
      red_hi_q <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      frame_q  <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      v0_q    <= bus.done_i;
      v1_q    <= v0_q;
      v2_q    <= v1_q;
      done_q  <= v2_q;
      frame_q <= frame_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (bus.done_i) win_q <= win_d;
      if (v0_q) begin
        lo_q <= lo_d;
        mi_q <= mi_d;
        hi_q <= hi_d;
      end
      if (v1_q) begin
        red_lo_q <= red_lo_d;
        red_mi_q <= red_mi_d;
        red_hi_q <= red_hi_d;
      end
      if (v2_q) data_q <= data_d;
    end
  end

  assign bus.data_o       = data_q;
  assign bus.done_o       = done_q;
  assign bus.frame_done_o = frame_q;

endmodule

// File: tb/tb_median_3x3_filter.sv
// Directed bench for median_3x3_filter with a 4x3 frame.
module tb_median_3x3_filter;
  localparam int unsigned W = 4;
  localparam int unsigned H = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   out_cnt = 0;

  logic [7:0] win_tbl [13][9];
  logic [7:0] med_tbl [13];

  always #5 clk = ~clk;

  median_3x3_filter_if bus ();

  median_3x3_filter #(
    .WIDTH (W),
    .HEIGHT(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic fill_tables();
    win_tbl[0]  = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    win_tbl[1]  = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    win_tbl[2]  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    win_tbl[3]  = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    win_tbl[4]  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    win_tbl[5]  = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    win_tbl[6]  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    win_tbl[7]  = '{8'd100, 8'd3, 8'd3, 8'd3, 8'd100, 8'd100, 8'd7, 8'd7, 8'd100};
    win_tbl[8]  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd200};
    win_tbl[9]  = '{8'd200, 8'd199, 8'd1, 8'd2, 8'd250, 8'd3, 8'd4, 8'd5, 8'd6};
    win_tbl[10] = '{8'd50, 8'd50, 8'd50, 8'd10, 8'd10, 8'd10, 8'd90, 8'd90, 8'd90};
    win_tbl[11] = '{8'd0, 8'd255, 8'd17, 8'd34, 8'd17, 8'd255, 8'd0, 8'd34, 8'd17};
    win_tbl[12] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    med_tbl = '{8'd5, 8'hAA, 8'd255, 8'd0, 8'd4, 8'd4, 8'd50, 8'd7, 8'd5, 8'd5, 8'd50, 8'd17,
                8'h80};
  endtask

  // Expected pixel for output number k of the frame given the true median m
  function automatic logic [7:0] exp_px(input int k, input logic [7:0] m);
`ifdef MEDIAN_BORDER_ZERO_EN
    int r;
    int c;
    r = (k % 12) / int'(W);
    c = k % int'(W);
    if (r == 0 || r == int'(H) - 1 || c == 0 || c == int'(W) - 1) return 8'h00;
`endif
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int idx);
    bus.done_i  = v;
    bus.data0_i = win_tbl[idx][0];
    bus.data1_i = win_tbl[idx][1];
    bus.data2_i = win_tbl[idx][2];
    bus.data3_i = win_tbl[idx][3];
    bus.data4_i = win_tbl[idx][4];
    bus.data5_i = win_tbl[idx][5];
    bus.data6_i = win_tbl[idx][6];
    bus.data7_i = win_tbl[idx][7];
    bus.data8_i = win_tbl[idx][8];
  endtask

  task automatic do_reset();
    drive(1'b0, 0);
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    out_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 0);
    step();
    step();
    step();
    step();
    total++;
    if (bus.done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %b want 0", bus.done_o);
    end
    total++;
    if (bus.data_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: got %0h want 0", bus.data_o);
    end
    total++;
    if (bus.frame_done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_frame: got %b want 0", bus.frame_done_o);
    end
    drive(1'b0, 0);
    rst = 1'b1;
    out_cnt = 0;
  endtask

  task automatic test_latency();
    logic [7:0] e;
    drive(1'b1, 0);
    for (int c = 0; c < 5; c++) begin
      step();
      drive(1'b0, 0);
      total++;
      if (bus.done_o !== (c == 3)) begin
        bad++;
        $display("FAIL latency_done c=%0d: got %b want %b", c, bus.done_o, c == 3);
      end
    end
    e = exp_px(0, med_tbl[0]);
    total++;
    if (bus.data_o !== e) begin
      bad++;
      $display("FAIL latency_data_hold: got %0h want %0h", bus.data_o, e);
    end
    out_cnt = 1;
  endtask

  task automatic test_corners();
    logic [7:0] e;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i);
      step();
      drive(1'b0, 0);
      step();
      step();
      step();
      e = exp_px(out_cnt, med_tbl[i]);
      total++;
      if (bus.done_o !== 1'b1 || bus.data_o !== e) begin
        bad++;
        $display("FAIL corner%0d: got done=%b data=%0h want done=1 data=%0h", i, bus.done_o,
                 bus.data_o, e);
      end
      total++;
      if (bus.frame_done_o !== 1'b0) begin
        bad++;
        $display("FAIL corner%0d_frame: got %b want 0", i, bus.frame_done_o);
      end
      out_cnt++;
    end
  endtask

  task automatic test_stream();
    bit         vseq [15];
    int         k;
    int         out_k;
    logic       exp_v;
    logic       exp_f;
    logic [7:0] last_px;
    logic [7:0] e;
    do_reset();
    vseq = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 1};
    k = 0;
    out_k = 0;
    last_px = 8'h00;
    for (int c = 0; c < 19; c++) begin
      if (c < 15) begin
        drive(vseq[c], k % 12);
        if (vseq[c]) k++;
      end else begin
        drive(1'b0, 0);
      end
      step();
      exp_v = (c >= 3 && c - 3 < 15) ? vseq[c-3] : 1'b0;
      exp_f = exp_v && (out_k % 12 == 11);
      total++;
      if (bus.done_o !== exp_v) begin
        bad++;
        $display("FAIL stream_done c=%0d: got %b want %b", c, bus.done_o, exp_v);
      end
      total++;
      if (bus.frame_done_o !== exp_f) begin
        bad++;
        $display("FAIL stream_frame c=%0d: got %b want %b", c, bus.frame_done_o, exp_f);
      end
      if (exp_v) begin
        e = exp_px(out_k, med_tbl[out_k % 12]);
        total++;
        if (bus.data_o !== e) begin
          bad++;
          $display("FAIL stream_data out=%0d: got %0h want %0h", out_k, bus.data_o, e);
        end
        last_px = e;
        out_k++;
      end else if (out_k > 0) begin
        total++;
        if (bus.data_o !== last_px) begin
          bad++;
          $display("FAIL stream_hold c=%0d: got %0h want %0h", c, bus.data_o, last_px);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic exp_f;
    do_reset();
    drive(1'b1, 4);
    step();
    drive(1'b1, 5);
    step();
    drive(1'b1, 6);
    step();
    drive(1'b0, 0);
    step();
    total++;
    if (bus.done_o !== 1'b1) begin
      bad++;
      $display("FAIL arst_pre_done: got %b want 1", bus.done_o);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (bus.done_o !== 1'b0 || bus.data_o !== 8'h00 || bus.frame_done_o !== 1'b0) begin
      bad++;
      $display("FAIL arst_immediate: got done=%b data=%0h frame=%b want 0/0/0", bus.done_o,
               bus.data_o, bus.frame_done_o);
    end
    step();
    step();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      total++;
      if (bus.done_o !== 1'b0) begin
        bad++;
        $display("FAIL arst_stale c=%0d: got %b want 0", c, bus.done_o);
      end
    end
    for (int c = 0; c < 15; c++) begin
      drive(c < 12, c % 12);
      step();
      exp_f = (c == 14);
      total++;
      if (bus.frame_done_o !== exp_f) begin
        bad++;
        $display("FAIL arst_frame c=%0d: got %b want %b", c, bus.frame_done_o, exp_f);
      end
    end
    drive(1'b0, 0);
  endtask

  task automatic test_border();
    logic [7:0] e;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      drive(c < 12, 12);
      step();
      if (c >= 3) begin
        e = exp_px(c - 3, 8'h80);
        total++;
        if (bus.done_o !== 1'b1 || bus.data_o !== e) begin
          bad++;
          $display("FAIL border p=%0d: got done=%b data=%0h want done=1 data=%0h", c - 3,
                   bus.done_o, bus.data_o, e);
        end
      end
    end
    drive(1'b0, 0);
  endtask

  initial begin
    fill_tables();
    test_reset();
    test_latency();
    test_corners();
    test_stream();
    test_async_reset();
    test_border();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
